// File: rtl/x7seg_if.sv
// Load/status/display bundle of the x7seg_scan display controller.
// The slave side is the controller; the master side is whoever loads it and owns the pins.
interface x7seg_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] x;
  logic              mode;
  logic              ld;
  logic              busy;
  logic              ovf;
  logic [6:0]        g_to_a;
  logic [NDIG-1:0]   an;

  modport master (
    output x, mode, ld,
    input  busy, ovf, g_to_a, an
  );

  modport slave (
    input  x, mode, ld,
    output busy, ovf, g_to_a, an
  );
endinterface

// File: rtl/x7seg_scan.sv
// Multiplexed common-anode seven-segment controller: hex or shift-add-3 decimal load, scanned output.
// Define X7SEG_BLANK_EN to blank leading-zero digits (digit 0 always lit, no blanking while ovf=1).
module x7seg_scan #(
  parameter int NDIG         = 4,
  parameter int BIN_W        = 14,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       clr,
  x7seg_if.slave     bus,
  output logic [0:0] dbg_state
);

  localparam int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = REFRESH_BITS + SEL_W;
  localparam int ACC_W = 4 * (NDIG + 1);
  localparam int BC_W  = $clog2(BIN_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic [0:0]        state;
  logic [4*NDIG-1:0] disp;
  logic              ovf_q;
  logic [BIN_W-1:0]  bin_q;
  logic [ACC_W-1:0]  acc;
  logic              carry_q;
  logic [BC_W-1:0]   bit_cnt;

  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_next;
  logic              carry_out;
  logic              last_shift;

  logic [CNT_W-1:0]        cnt;
  logic [SEL_W-1:0]        sel;
  logic [REFRESH_BITS-1:0] dwell;
  logic                    wrap;

  logic [NDIG-1:0] blank;
  logic [3:0]      cur_digit;
  logic            cur_blank;
  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;

  // Handshake: ld is a single-cycle strobe taken at a rising edge only when busy=0
  // (state IDLE); while busy=1 it is dropped, never queued.
  assign bus.busy   = (state == S_CONV);
  assign bus.ovf    = ovf_q;
  assign bus.g_to_a = seg_q;
  assign bus.an     = an_q;
  assign dbg_state  = state;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Shift-add-3 step: correct every BCD digit that would exceed 9 after doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i <= NDIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_next   = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
    carry_out  = acc_adj[ACC_W-1];
    last_shift = (bit_cnt == BC_W'(BIN_W - 1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      disp    <= '0;
      ovf_q   <= 1'b0;
      bin_q   <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ld) begin
            if (bus.mode) begin
              bin_q   <= bus.x[BIN_W-1:0];
              acc     <= '0;
              carry_q <= 1'b0;
              bit_cnt <= '0;
              state   <= S_CONV;
            end else begin
              disp  <= bus.x;
              ovf_q <= 1'b0;
            end
          end
        end
        S_CONV: begin
          acc     <= acc_next;
          bin_q   <= bin_q << 1;
          carry_q <= carry_q | carry_out;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (last_shift) begin
            disp  <= acc_next[4*NDIG-1:0];
            ovf_q <= (|acc_next[ACC_W-1 -: 4]) | carry_q | carry_out;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scan counter: upper bits pick the digit, lower bits set the dwell; it wraps
  // early so a non-power-of-two digit count never selects a missing digit.
  assign sel   = cnt[CNT_W-1 -: SEL_W];
  assign dwell = cnt[REFRESH_BITS-1:0];
  assign wrap  = (sel == SEL_W'(NDIG - 1)) && (&dwell);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    blank = '0;
`ifdef X7SEG_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
        zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
        blank[i]   = zero_above && !ovf_q;
      end
    end
`endif
  end

  assign cur_digit = disp[4*int'(sel) +: 4];
  assign cur_blank = blank[sel];

  // Pin registers lag sel/disp by one clock; overflow forces dashes on every digit.
  always_ff @(posedge clk) begin
    if (clr) begin
      seg_q <= SEG_OFF;
      an_q  <= '1;
    end else begin
      if (ovf_q) begin
        seg_q <= SEG_DASH;
      end else if (cur_blank) begin
        seg_q <= SEG_OFF;
      end else begin
        seg_q <= seg7(cur_digit);
      end
      an_q <= cur_blank ? {NDIG{1'b1}} : ~(NDIG'(1) << sel);
    end
  end

endmodule

// File: tb/tb_x7seg_scan.sv
// Randomised scoreboard bench for x7seg_scan: loads are queued as expected {mode,ovf,disp}
// entries and a negedge monitor checks status and every scanned digit against a decimal model.
module tb_x7seg_scan;
  localparam int NDIG  = 4;
  localparam int BIN_W = 14;
  localparam int RB    = 2;
  localparam int DW    = 4 * NDIG;
  localparam int EW    = DW + 2;

  logic       clk = 1'b0;
  logic       clr;
  logic [0:0] dbg_state;

  x7seg_if #(.NDIG(NDIG)) bus ();

  x7seg_scan #(.NDIG(NDIG), .BIN_W(BIN_W), .REFRESH_BITS(RB)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int to_cnt = 0;
  bit done = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Decimal reference: digit i of v in BCD, overflow when v needs more than NDIG digits.
  function automatic logic [EW-1:0] dec_exp(input int v);
    logic [DW-1:0] d;
    int p;
    d = '0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      d[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {1'b1, (v >= p), d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit            armed = 1'b0;
  bit            final_done = 1'b0;
  bit            prev_clr = 1'b0, prev_ld = 1'b0, prev_mode = 1'b0, prev_busy = 1'b0;
  int            j = 0;
  int            busy_len = 0;
  logic [DW-1:0] m_disp = '0, md_disp = '0;
  logic          m_ovf = 1'b0, md_ovf = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0]   e;
    logic [NDIG-1:0] exp_an;
    logic [6:0]      exp_seg;
    logic [3:0]      dig;
    bit              blanked;
    int              sel;
    if (prev_clr) begin
      armed    = 1'b1;
      j        = 0;
      busy_len = 0;
      m_disp   = '0;
      m_ovf    = 1'b0;
      md_disp  = '0;
      md_ovf   = 1'b0;
      exp_q.delete();
      chk(bus.g_to_a === 7'h7F, "rst_seg", 32'(bus.g_to_a), 32'h7F);
      chk(bus.an === {NDIG{1'b1}}, "rst_an", 32'(bus.an), 32'((1 << NDIG) - 1));
      chk(bus.busy === 1'b0, "rst_busy", 32'(bus.busy), 0);
      chk(bus.ovf === 1'b0, "rst_ovf", 32'(bus.ovf), 0);
    end else if (armed) begin
      j++;
      sel     = ((j - 1) / (1 << RB)) % NDIG;
      dig     = 4'((md_disp >> (4 * sel)) & 'hF);
      blanked = 1'b0;
`ifdef X7SEG_BLANK_EN
      blanked = !md_ovf && (sel > 0) && ((md_disp >> (4 * sel)) == 0);
`endif
      exp_an  = blanked ? {NDIG{1'b1}} : ~(NDIG'(1) << sel);
      exp_seg = md_ovf ? 7'b0111111 : seg_tab[dig];
      chk(bus.an === exp_an, "scan_an", 32'(bus.an), 32'(exp_an));
      if (!blanked) chk(bus.g_to_a === exp_seg, "scan_seg", 32'(bus.g_to_a), 32'(exp_seg));

      if (prev_ld && !prev_mode && !prev_busy) begin
        chk(exp_q.size() != 0, "hex_expected", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(e[EW-1] == 1'b0, "hex_order", 32'(e[EW-1]), 0);
          m_disp = e[DW-1:0];
          m_ovf  = e[DW];
        end
      end

      if (prev_busy && !bus.busy) begin
        chk(busy_len == BIN_W, "busy_len", 32'(busy_len), 32'(BIN_W));
        busy_len = 0;
        chk(exp_q.size() != 0, "dec_expected", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(e[EW-1] == 1'b1, "dec_order", 32'(e[EW-1]), 1);
          chk(bus.ovf === e[DW], "dec_ovf", 32'(bus.ovf), 32'(e[DW]));
          m_disp = e[DW-1:0];
          m_ovf  = e[DW];
        end
      end
      if (bus.busy === 1'b1) busy_len++;
      chk(bus.ovf === m_ovf, "ovf", 32'(bus.ovf), 32'(m_ovf));
    end

    if (done && !final_done) begin
      final_done = 1'b1;
      chk(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 0);
      chk(to_cnt == 0, "busy_timeout", 32'(to_cnt), 0);
    end

    md_disp   = m_disp;
    md_ovf    = m_ovf;
    prev_clr  = clr;
    prev_ld   = bus.ld;
    prev_mode = bus.mode;
    prev_busy = (bus.busy === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy !== 1'b0) to_cnt++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (n) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hex_load(input logic [DW-1:0] v);
    @(posedge clk); #1;
    bus.x = v; bus.mode = 1'b0; bus.ld = 1'b1;
    exp_q.push_back({1'b0, 1'b0, v});
    @(posedge clk); #1;
    bus.ld = 1'b0;
  endtask

  // With pulse set, extra ld strobes land on the first and last conversion edges.
  task automatic dec_load(input int v, input bit pulse);
    @(posedge clk); #1;
    bus.x = DW'(v); bus.mode = 1'b1; bus.ld = 1'b1;
    exp_q.push_back(dec_exp(v));
    @(posedge clk); #1;
    bus.ld = 1'b0;
    if (pulse) begin
      bus.ld = 1'b1; bus.x = DW'(7);
      @(posedge clk); #1;
      bus.ld = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      bus.ld = 1'b1; bus.mode = 1'b0; bus.x = DW'('h1111);
      @(posedge clk); #1;
      bus.ld = 1'b0;
    end
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; bus.x = '0; bus.mode = 1'b0; bus.ld = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    idle(10);

    hex_load(DW'('h00A5));
    idle(20);
    dec_load(9999, 1'b0);
    idle(20);
    dec_load(12345, 1'b0);
    idle(20);
    dec_load(42, 1'b1);
    idle(20);

    idle(5);
    do_reset(3);
    idle(6);

    // Abort a conversion of 1234 on its seventh shift edge, then reload.
    @(posedge clk); #1;
    bus.x = DW'(1234); bus.mode = 1'b1; bus.ld = 1'b1;
    exp_q.push_back(dec_exp(1234));
    @(posedge clk); #1;
    bus.ld = 1'b0;
    repeat (6) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    idle(3);
    dec_load(7, 1'b0);
    idle(20);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int nd;
        logic [DW-1:0] v;
        nd = $urandom_range(1, NDIG);
        v  = DW'($urandom);
        v  = v & DW'((64'd1 << (4 * nd)) - 1);
        hex_load(v);
      end else begin
        dec_load(int'($urandom_range(0, (1 << BIN_W) - 1)), ($urandom_range(0, 3) == 0));
      end
      idle($urandom_range(0, 20));
    end
    idle(20);

    done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
